rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Round-robin arbiter and read sequencer that shares one synchronous 16x4 ROM (`clk`/`en`/`addr`/`dout` port) between NREQ independent requesters. It accepts at most one read per cycle, drives the ROM enable and address from registers, and returns each ROM word to the requester that issued it. It sits between the ROM instance and the client blocks that would otherwise each need a private ROM copy.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- ADDR_W, 4: ROM address width.
- DATA_W, 4: ROM data width.
- RD_LAT, 1: ROM read latency, in cycles from the `rom_en` sample edge to valid `rom_dout`.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester read request; held until granted.
- addr  in  NREQ*ADDR_W  per-requester address; slice i belongs to requester i.
- gnt  out  NREQ  combinational one-hot grant; a transfer occurs at a rising edge where req[i]&gnt[i].
- rvalid  out  NREQ  one-hot; single-cycle pulse marking returned data for requester i.
- rdata  out  DATA_W  returned word; meaningful only while some rvalid bit is high.
- rom_en  out  1  registered ROM enable.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_dout  in  DATA_W  ROM read data.
- cnt  out  NREQ*8  per-requester count of completed reads; saturates at 255.

## Operation
- Arbitration: round-robin pointer `ptr`. Search order starts at ptr, i.e. ptr, ptr+1, …, wrapping modulo NREQ. The first requester in that order with req high gets gnt. gnt is all-zero when req is zero.
- After a transfer by requester i, ptr becomes (i+1) mod NREQ. ptr holds when no transfer occurs.
- Issue: on a transfer edge, rom_en<=1 and rom_addr<=addr slice of the winner. On a non-transfer edge, rom_en<=0 and rom_addr holds its value.
- Tag pipeline: an RD_LAT+1 deep shift register carries {valid, id}. It is loaded with {1, winner} on a transfer edge and {0, x} otherwise. Its output drives rvalid[id].
- rdata is a direct pass-through of rom_dout.
- Each rvalid pulse for requester i increments cnt[i] on the next edge. A counter at 255 stays at 255.
- Back-to-back operation: one read per cycle is sustained. A requester holding req high through consecutive edges is regranted only when the other requesters are idle.
- Requester contract: addr must be stable while req is high. A requester may drop req only after its transfer edge.

## Timing
- Reset values: rom_en=0, rom_addr=0, rvalid=0, tag pipeline all invalid, ptr=0, cnt=0. gnt follows req/ptr combinationally even in reset, but no transfer is recorded while rst_n=0.
- Latency with RD_LAT=1:
  - Transfer at edge k.
  - rom_en high during cycle k.
  - ROM samples at edge k+1.
  - rvalid and rdata valid during the cycle after edge k+1 (sampled at edge k+2).
  - Total: 2 edges from transfer to data.
- Simultaneous requests: exactly one gnt per cycle. Losers keep req high and are served in pointer order, with no starvation. Worst case wait is NREQ-1 cycles.
- Reset mid-operation: asserting rst_n low clears in-flight tags immediately. No rvalid is produced for reads issued before reset, and cnt returns to 0.
- The tag pipeline is always valid-gated, so an X or stale rom_dout is never flagged valid.

## Structure
- Package `rom_ctrl_pkg` holds ADDR_W, DATA_W, the default NREQ, the CNT_W=8 constant, and the tag struct type {valid, id}.
- Sub-module `rr_pick` is a combinational round-robin one-hot picker with inputs req and ptr and outputs gnt and the winner index. The top level holds all registers.

## Test plan
- Single read: req[0]=1, addr0=4'hA at edge 1. Expect gnt[0]=1 in cycle 0, rom_en=1/rom_addr=A in cycle 1, rvalid[0]=1 with rdata=ROM[A] in cycle 2, and cnt[0]=1.
- Contention: req[0] and req[1] high with addresses D and 8 from ptr=0. Expect grant order 0,1,0,1 and rvalid alternating each cycle with the matching data.
- Streaming: requester 1 alone holds req for 16 cycles with addresses 0..F. Expect 16 consecutive rvalid[1] pulses in order with no bubbles.
- Idle gap: req low for 3 cycles. Expect rom_en=0 and rvalid=0 throughout, with rom_addr and ptr held.
- Reset mid-flight: issue a read, then pull rst_n low one cycle later. Expect no rvalid, and all outputs at reset values immediately.
- Saturation: 260 reads by requester 0. Expect cnt[0]=255 and cnt[1]=0.

Source files
------------

// File: rtl/rom_ctrl_pkg.sv
// Shared constants and the return-tag type for the ROM arbiter slice.
package rom_ctrl_pkg;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 4;
  localparam int NREQ_DEF = 2;
  localparam int CNT_W    = 8;
  // Requester index width; wide enough for the largest legal NREQ of 4.
  localparam int ID_W     = 2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] win
);
  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr is always below NREQ, so one subtraction wraps the search.
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one synchronous ROM between NREQ requesters,
// with a valid-gated tag pipeline routing each returned word to its issuer.
module rom_arbiter #(
  parameter int NREQ   = rom_ctrl_pkg::NREQ_DEF,
  parameter int ADDR_W = rom_ctrl_pkg::ADDR_W,
  parameter int DATA_W = rom_ctrl_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_dout,
  output logic [NREQ*8-1:0]        cnt
);
  import rom_ctrl_pkg::*;

  logic [ID_W-1:0]              ptr;
  logic [ID_W-1:0]              win;
  logic                         xfer;
  tag_t                         tag_p [RD_LAT+1];
  logic [NREQ-1:0][CNT_W-1:0]   cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .win (win)
  );

  assign xfer = |(req & gnt);

  // Issue stage: register ROM enable/address and advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= xfer;
      if (xfer) begin
        rom_addr <= addr[int'(win)*ADDR_W +: ADDR_W];
        ptr      <= (win == ID_W'(NREQ-1)) ? '0 : win + 1'b1;
      end
    end
  end

  // Tag stages: {valid, id} travels alongside the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= RD_LAT; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= '{valid: xfer, id: win};
      for (int k = 1; k <= RD_LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++)
      rvalid[i] = tag_p[RD_LAT].valid && (tag_p[RD_LAT].id == ID_W'(i));
  end

  assign rdata = rom_dout;

  // Completion stage: count each returned word per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (rvalid[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
    end
  end

  assign cnt = cnt_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic against a
// transaction-level reference of grant order, read latency and counters.
module tb_rom_arbiter;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] addr = '0;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   rom_en;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_dout = '0;
  logic [NREQ*8-1:0]      cnt;

  logic [DATA_W-1:0] rom_mem [16];

  rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) if (rom_en) rom_dout <= rom_mem[rom_addr];

  // Reference state: pointer, last two transfers, issued address, counts.
  int                ptr_m;
  int                x0_id, x1_id;
  logic [ADDR_W-1:0] x0_addr, x1_addr;
  logic [ADDR_W-1:0] rom_addr_m;
  int                cnt_m [NREQ];
  int                last_w;
  int                n_vec = 0;
  int                n_err = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m      = 0;
    x0_id      = -1;
    x1_id      = -1;
    x0_addr    = '0;
    x1_addr    = '0;
    rom_addr_m = '0;
    last_w     = -1;
    for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
  endtask

  task automatic check();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ev;
    int w;
    w  = pick(req, ptr_m);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    ev = '0;
    if (x1_id >= 0) ev[x1_id] = 1'b1;
    n_vec++;
    assert (gnt === eg) else begin n_err++; $error("FAIL gnt: got %b want %b", gnt, eg); end
    n_vec++;
    assert (rom_en === (x0_id >= 0)) else begin n_err++; $error("FAIL rom_en: got %b want %b", rom_en, (x0_id >= 0)); end
    n_vec++;
    assert (rom_addr === rom_addr_m) else begin n_err++; $error("FAIL rom_addr: got %h want %h", rom_addr, rom_addr_m); end
    n_vec++;
    assert (rvalid === ev) else begin n_err++; $error("FAIL rvalid: got %b want %b", rvalid, ev); end
    if (x1_id >= 0) begin
      n_vec++;
      assert (rdata === rom_mem[x1_addr]) else begin
        n_err++; $error("FAIL rdata: got %h want %h", rdata, rom_mem[x1_addr]);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      n_vec++;
      assert (cnt[i*8 +: 8] === 8'(cnt_m[i])) else begin
        n_err++; $error("FAIL cnt%0d: got %0d want %0d", i, cnt[i*8 +: 8], cnt_m[i]);
      end
    end
  endtask

  // Advance the reference across one rising edge.
  task automatic update();
    int w;
    if (rst_n) begin
      w = pick(req, ptr_m);
      if (x1_id >= 0 && cnt_m[x1_id] < 255) cnt_m[x1_id]++;
      x1_id   = x0_id;
      x1_addr = x0_addr;
      x0_id   = w;
      if (w >= 0) begin
        x0_addr    = addr[w*ADDR_W +: ADDR_W];
        rom_addr_m = x0_addr;
        ptr_m      = (w + 1) % NREQ;
      end
      last_w = w;
    end else begin
      last_w = -1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic set_addr(input int i, input int a);
    addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  // Random requester behaviour that honours the hold-until-granted contract.
  task automatic rand_update();
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (last_w == i) begin
          req[i] = 1'($urandom_range(1));
          set_addr(i, int'($urandom_range(15)));
        end
      end else if ($urandom_range(2) == 0) begin
        req[i] = 1'b1;
        set_addr(i, int'($urandom_range(15)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = DATA_W'((i * 7 + 3) % 16);
    model_reset();
    #1;

    // Reset state, including gnt following req while in reset.
    cycle();
    req = 2'b10;
    cycle();
    req = '0;
    rst_n = 1'b1;
    cycle();

    // Contention from ptr=0: grants 0,1,0,1.
    req = 2'b11;
    set_addr(0, 'hD);
    set_addr(1, 'h8);
    cycle();
    cycle();
    cycle();
    req[0] = 1'b0;
    cycle();
    req = '0;
    cycle();
    cycle();

    // Single read of address A by requester 0.
    req = 2'b01;
    set_addr(0, 'hA);
    cycle();
    req = '0;
    repeat (3) cycle();

    // Streaming: requester 1 alone, addresses 0..F back to back.
    req = 2'b10;
    for (int a = 0; a < 16; a++) begin
      set_addr(1, a);
      cycle();
    end
    req = '0;

    // Idle gap: nothing issued, address and pointer held.
    repeat (3) cycle();
    req = 2'b11;
    set_addr(0, 3);
    set_addr(1, 9);
    cycle();
    cycle();
    req = '0;
    repeat (2) cycle();

    // Reset while a read is in flight.
    req = 2'b01;
    set_addr(0, 5);
    cycle();
    req = '0;
    cycle();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    // Saturation: 260 reads by requester 0.
    req = 2'b01;
    for (int k = 0; k < 260; k++) begin
      set_addr(0, k % 16);
      cycle();
    end
    req = '0;
    repeat (3) cycle();
    n_vec++;
    assert (cnt[7:0] === 8'd255) else begin n_err++; $error("FAIL sat_cnt0: got %0d want 255", cnt[7:0]); end
    n_vec++;
    assert (cnt[15:8] === 8'd0) else begin n_err++; $error("FAIL sat_cnt1: got %0d want 0", cnt[15:8]); end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle();
      rand_update();
    end
    req = '0;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
